// File: rtl/regfile_arb_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } arbState_e;

  localparam int DEFAULT_NUM_REQ = 3;
  localparam int DEFAULT_ADDR_W  = 2;
  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_CNT_W   = 16;

  // A single requester still needs a 1-bit pointer so the port is never zero-width.
  function automatic int ptrWidth(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting index scanning Ptr, Ptr+1, ... mod NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [PTR_W-1:0]   Ptr,
  output logic [NUM_REQ-1:0] Grant,
  output logic [PTR_W-1:0]   Index,
  output logic               Valid
);

  int cand;

  // NOTE: every output is given a default before the search loop so no path
  // leaves it unassigned; a missing default here would infer a latch.
  always_comb begin
    Grant = '0;
    Index = '0;
    Valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(Ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!Valid && (i == cand) && Req[i]) begin
          Valid    = 1'b1;
          Grant[i] = 1'b1;
          Index    = PTR_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Optional REGFILE_ARB_ZERO_DROP_EN: granted writes to register 0 are consumed without a RegWrite.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [NUM_REQ-1:0]        Grant,
  input  logic                      Stall,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteRegister,
  output logic [DATA_W-1:0]         WriteData,
  output logic                      Busy,
  output logic [CNT_W-1:0]          WriteCount
);

  localparam int PTR_W = ptrWidth(NUM_REQ);

  arbState_e          state;
  arbState_e          stateNext;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptrNext;
  logic [PTR_W-1:0]   pickIndex;
  logic [NUM_REQ-1:0] eligibleReq;
  logic [NUM_REQ-1:0] pickGrant;
  logic               pickValid;
  logic               canGrant;
  logic               issueWrite;
  logic [ADDR_W-1:0]  selAddr;
  logic [DATA_W-1:0]  selData;

  // Reset, Stall and the STALL state all mask requests before the pick, so Grant is zero then.
  assign canGrant    = !Reset && !Stall && (state != STALL);
  assign eligibleReq = canGrant ? Req : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .Req   (eligibleReq),
    .Ptr   (ptr),
    .Grant (pickGrant),
    .Index (pickIndex),
    .Valid (pickValid)
  );

  assign Grant = pickGrant;
  assign Busy  = (state != IDLE);

  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickGrant[i]) begin
        selAddr = ReqAddr[i*ADDR_W +: ADDR_W];
        selData = ReqData[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGFILE_ARB_ZERO_DROP_EN
  // Register 0 reads as zero, so its writes are accepted but never reach the port.
  assign issueWrite = pickValid && (selAddr != '0);
`else
  assign issueWrite = pickValid;
`endif

  always_comb begin
    ptrNext = ptr;
    if (pickValid) begin
      ptrNext = (int'(pickIndex) == NUM_REQ - 1) ? '0 : pickIndex + PTR_W'(1);
    end
  end

  always_comb begin
    stateNext = state;
    if (Stall) begin
      stateNext = STALL;
    end else begin
      unique case (state)
        IDLE:    stateNext = pickValid ? WRITE : IDLE;
        WRITE:   stateNext = pickValid ? WRITE : IDLE;
        STALL:   stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
    end
  end

  // Write port: a grant at edge t drives exactly one RegWrite cycle; reset drops anything pending.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= issueWrite;
      if (issueWrite) begin
        WriteRegister <= selAddr;
        WriteData     <= selData;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      WriteCount <= '0;
    end else if (issueWrite && (WriteCount != '1)) begin
      WriteCount <= WriteCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: grants checked inline, write port checked by a queue monitor.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;

  logic                      Clk = 1'b0;
  logic                      Reset;
  logic                      Stall;
  logic [NUM_REQ-1:0]        Req;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ*DATA_W-1:0] ReqData;
  logic [NUM_REQ-1:0]        Grant;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         WriteRegister;
  logic [DATA_W-1:0]         WriteData;
  logic                      Busy;
  logic [CNT_W-1:0]          WriteCount;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                due;
  } wrExp_t;

  wrExp_t sbQ[$];

  arbState_e         expState  = IDLE;
  int                expPtr    = 0;
  logic [CNT_W-1:0]  expCount  = '0;
  int                pendIdx   = -1;
  logic              pendIssue = 1'b0;

  regfile_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Req           (Req),
    .ReqAddr       (ReqAddr),
    .ReqData       (ReqData),
    .Grant         (Grant),
    .Stall         (Stall),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Busy          (Busy),
    .WriteCount    (WriteCount)
  );

  always #5 Clk = ~Clk;

  task automatic setSrc(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ReqAddr[i*ADDR_W +: ADDR_W] = a;
    ReqData[i*DATA_W +: DATA_W] = d;
  endtask

  // Waits for the negedge, predicts this cycle's grant and queues the write it should produce.
  task automatic sample(output logic [NUM_REQ-1:0] expG);
    wrExp_t e;
    int c;
    @(negedge Clk);
    expG      = '0;
    pendIdx   = -1;
    pendIssue = 1'b0;
    if (!Reset && !Stall && expState != STALL) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (expPtr + k) % NUM_REQ;
        if (pendIdx < 0 && Req[c]) pendIdx = c;
      end
    end
    if (pendIdx >= 0) begin
      expG      = NUM_REQ'(1) << pendIdx;
      e.addr    = ReqAddr[pendIdx*ADDR_W +: ADDR_W];
      e.data    = ReqData[pendIdx*DATA_W +: DATA_W];
      e.due     = cycle + 1;
      pendIssue = 1'b1;
`ifdef REGFILE_ARB_ZERO_DROP_EN
      if (e.addr == '0) pendIssue = 1'b0;
`endif
      if (pendIssue) sbQ.push_back(e);
    end
  endtask

  task automatic advance();
    @(posedge Clk);
    if (Reset) begin
      expState = IDLE;
      expPtr   = 0;
      expCount = '0;
      sbQ.delete();
    end else begin
      if (Stall)                  expState = STALL;
      else if (expState == STALL) expState = IDLE;
      else                        expState = (pendIdx >= 0) ? WRITE : IDLE;
      if (pendIdx >= 0) expPtr = (pendIdx + 1) % NUM_REQ;
      if (pendIssue && expCount != '1) expCount = expCount + 1'b1;
    end
    cycle++;
    #1;
  endtask

  // Write-port monitor: each queued write must appear exactly in its due cycle.
  always @(negedge Clk) begin
    while (sbQ.size() > 0 && sbQ[0].due < cycle) begin
      checks++;
      errors++;
      $display("FAIL sb_missing: write addr=%0d data=%h due cycle %0d never seen", sbQ[0].addr, sbQ[0].data, sbQ[0].due);
      sbQ.pop_front();
    end
    checks++;
    if (sbQ.size() > 0 && sbQ[0].due == cycle) begin
      if (RegWrite !== 1'b1 || WriteRegister !== sbQ[0].addr || WriteData !== sbQ[0].data) begin
        errors++;
        $display("FAIL sb_write: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h (cycle %0d)",
                 RegWrite, WriteRegister, WriteData, sbQ[0].addr, sbQ[0].data, cycle);
      end
      sbQ.pop_front();
    end else if (RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL sb_idle: got RegWrite=%b expected 0 (cycle %0d)", RegWrite, cycle);
    end
    checks++;
    if (WriteCount !== expCount) begin
      errors++;
      $display("FAIL write_count: got %h expected %h (cycle %0d)", WriteCount, expCount, cycle);
    end
  end

  task automatic test_reset();
    logic [NUM_REQ-1:0] g;
    Reset = 1'b1; Stall = 1'b0; Req = 3'b111;
    ReqAddr = '0; ReqData = '0;
    for (int n = 0; n < 2; n++) begin
      sample(g);
      checks++;
      if (Grant !== 3'b000 || RegWrite !== 1'b0 || WriteCount !== '0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: got grant=%b we=%b cnt=%h busy=%b expected 000/0/0000/0", Grant, RegWrite, WriteCount, Busy);
      end
      advance();
    end
    Reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] seqG [4];
    logic [ADDR_W-1:0]  seqA [4];
    seqG = '{3'b001, 3'b010, 3'b100, 3'b001};
    seqA = '{2'd1, 2'd2, 2'd3, 2'd1};
    setSrc(0, 2'd1, 32'h0000_000A);
    setSrc(1, 2'd2, 32'h0000_000B);
    setSrc(2, 2'd3, 32'h0000_000C);
    Req = 3'b111;
    for (int n = 0; n < 5; n++) begin
      if (n == 4) Req = 3'b000;
      sample(g);
      if (n < 4) begin
        checks++;
        if (Grant !== seqG[n]) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got %b expected %b", n, Grant, seqG[n]);
        end
      end
      if (n > 0) begin
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== seqA[n-1]) begin
          errors++;
          $display("FAIL rr_port[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", n, RegWrite, WriteRegister, seqA[n-1]);
        end
      end
      advance();
    end
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] g;
    setSrc(1, 2'd2, 32'hDEAD_BEEF);
    Req = 3'b010;
    sample(g);
    checks++;
    if (Grant !== 3'b010) begin
      errors++;
      $display("FAIL single_grant: got %b expected 010", Grant);
    end
    advance();
    Req = 3'b000;
    sample(g);
    checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 2'd2 || WriteData !== 32'hDEAD_BEEF || Grant !== 3'b000) begin
      errors++;
      $display("FAIL single_port: got we=%b addr=%0d data=%h grant=%b expected 1/2/deadbeef/000",
               RegWrite, WriteRegister, WriteData, Grant);
    end
    advance();
    sample(g);
    checks++;
    if (RegWrite !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got we=%b busy=%b expected 0/0", RegWrite, Busy);
    end
    advance();
  endtask

  task automatic test_stall();
    logic [NUM_REQ-1:0] g;
    setSrc(0, 2'd1, 32'h0000_1111);
    setSrc(1, 2'd2, 32'h0000_2222);
    Req = 3'b011; Stall = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (n == 3) Stall = 1'b0;
      sample(g);
      checks++;
      if (Grant !== 3'b000 || (n > 0 && Busy !== 1'b1)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got grant=%b busy=%b expected 000/1", n, Grant, Busy);
      end
      advance();
    end
    sample(g);
    checks++;
    if (Grant !== g || Grant !== 3'b001 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got grant=%b busy=%b expected %b/0", Grant, Busy, g);
    end
    advance();
    Req = 3'b000;
    sample(g);
    advance();
  endtask

  task automatic test_same_addr();
    logic [NUM_REQ-1:0] g;
    setSrc(2, 2'd3, 32'd22);
    Req = 3'b100;
    sample(g);
    checks++;
    if (Grant !== g) begin
      errors++;
      $display("FAIL same_setup: got %b expected %b", Grant, g);
    end
    advance();
    setSrc(0, 2'd3, 32'd11);
    for (int pass = 0; pass < 2; pass++) begin
      Req = 3'b101;
      sample(g);
      checks++;
      if (Grant !== 3'b001) begin
        errors++;
        $display("FAIL same_first[%0d]: got %b expected 001", pass, Grant);
      end
      advance();
      Req = 3'b100;
      if (pass == 1) Reset = 1'b1;
      sample(g);
      checks++;
      if (Grant !== ((pass == 0) ? 3'b100 : 3'b000) || RegWrite !== 1'b1 || WriteData !== 32'd11) begin
        errors++;
        $display("FAIL same_second[%0d]: got grant=%b we=%b data=%0d expected grant=%b we=1 data=11",
                 pass, Grant, RegWrite, WriteData, (pass == 0) ? 3'b100 : 3'b000);
      end
      advance();
      Reset = 1'b0;
      Req = 3'b000;
      sample(g);
      checks++;
      if (pass == 0 && (RegWrite !== 1'b1 || WriteData !== 32'd22)) begin
        errors++;
        $display("FAIL same_order: got we=%b data=%0d expected we=1 data=22", RegWrite, WriteData);
      end else if (pass == 1 && (RegWrite !== 1'b0 || WriteCount !== '0 || Busy !== 1'b0)) begin
        errors++;
        $display("FAIL same_reset_drop: got we=%b cnt=%h busy=%b expected 0/0000/0", RegWrite, WriteCount, Busy);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    logic [NUM_REQ-1:0] g;
    setSrc(0, 2'd1, 32'h5A5A_0000);
    Req = 3'b001;
    for (int n = 0; n < 65534; n++) begin
      sample(g);
      checks++;
      if (Grant !== g) begin
        errors++;
        $display("FAIL sat_grant[%0d]: got %b expected %b", n, Grant, g);
      end
      advance();
    end
    sample(g);
    checks++;
    if (WriteCount !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_fffe: got %h expected fffe", WriteCount);
    end
    advance();
    for (int n = 0; n < 2; n++) begin
      sample(g);
      advance();
    end
    Req = 3'b000;
    sample(g);
    advance();
    sample(g);
    checks++;
    if (WriteCount !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h expected ffff", WriteCount);
    end
    advance();
  endtask

  task automatic test_zero_addr();
    logic [NUM_REQ-1:0] g;
    Reset = 1'b1;
    sample(g);
    advance();
    Reset = 1'b0;
    setSrc(0, 2'd0, 32'h1234_5678);
    Req = 3'b001;
    sample(g);
    checks++;
    if (Grant !== 3'b001) begin
      errors++;
      $display("FAIL zero_grant: got %b expected 001", Grant);
    end
    advance();
    Req = 3'b000;
    sample(g);
    checks++;
`ifdef REGFILE_ARB_ZERO_DROP_EN
    if (RegWrite !== 1'b0 || WriteCount !== '0) begin
      errors++;
      $display("FAIL zero_drop: got we=%b cnt=%h expected 0/0000", RegWrite, WriteCount);
    end
`else
    if (RegWrite !== 1'b1 || WriteRegister !== 2'd0 || WriteData !== 32'h1234_5678 || WriteCount !== 16'd1) begin
      errors++;
      $display("FAIL zero_issue: got we=%b addr=%0d data=%h cnt=%h expected 1/0/12345678/0001",
               RegWrite, WriteRegister, WriteData, WriteCount);
    end
`endif
    advance();
    sample(g);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d queued writes expected 0", sbQ.size());
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_same_addr();
    test_saturation();
    test_zero_addr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
